load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the single-cycle RISC-V data memory. It turns core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memRead/memWrite accesses on the 32-word data memory. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Load results are sign- or zero-extended. The unit sits between the execute stage and the data memory and adds a multi-cycle handshake on the core side.

## Interface
Parameters:
- IDX_BITS, 5, word-index width; memory depth is 2^IDX_BITS words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  core request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte or halfword used for SB/SH.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; request was rejected and no memory access was made.
- rdata  out  32  load result; updated only on successful loads.
- mem_read  out  1  to data memory memRead.
- mem_write  out  1  to data memory memWrite.
- mem_addr  out  IDX_BITS  word index, equal to addr[IDX_BITS+1:2].
- mem_wdata  out  32  to data memory writeData.
- mem_rdata  in  32  from data memory readData, which is registered (valid the cycle after mem_read).

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE, on req=1, latches we/funct3/addr/wdata and moves to:
  - DONE with err flagged, if the request is invalid;
  - WR, for SW;
  - RD, for all loads and for SB/SH.
- Invalid requests:
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1;
  - misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- RD: mem_read=1 for exactly one cycle, then CAP.
- CAP: mem_rdata is valid.
  - Load: rdata is registered from the selected lane, then DONE.
    - Byte lane is addr[1:0]; halfword lane is addr[1].
    - Little-endian: byte 0 = bits 7:0.
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - SB/SH: the merged word (new lane inserted, other lanes kept from mem_rdata) is registered into a write buffer, then WR.
- WR: mem_write=1 for exactly one cycle, with mem_wdata = write buffer (SW: latched wdata), then DONE.
- DONE: done=1 for one cycle, err as decided, then IDLE.
- mem_read and mem_write are decoded from state only. They are never both high.
- mem_addr is held stable from RD/WR entry through DONE.
- req while busy is ignored. The core holds off until done.
- A new req may be accepted in the IDLE cycle directly after DONE.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, mem_read 0, mem_write 0, mem_wdata 0, write buffer 0.
- Latency, counted from the edge that accepts req to the cycle done is high:
  - SW: 2 cycles (WR, DONE).
  - Loads: 3 cycles (RD, CAP, DONE).
  - SB/SH: 4 cycles (RD, CAP, WR, DONE).
  - Rejected requests: 1 cycle.
- Reset asserted mid-operation:
  - Immediately forces IDLE and drops mem_read/mem_write.
  - No partial write reaches memory, because mem_write is asserted only in WR.
  - A pending done is lost.
- err is held until the next accepted request. It is cleared when the next req is accepted.

## Configuration
- LSU_RANGE_CHECK_EN defined: addr[31:IDX_BITS+2] != 0 is treated as an invalid request (err=1, no memory access, 1-cycle latency).
- LSU_RANGE_CHECK_EN undefined: upper address bits are ignored and addresses alias modulo 2^(IDX_BITS+2) bytes.

## Test plan
- SW wdata=0xDEADBEEF, addr=0x10 → one cycle with mem_write=1, mem_addr=4, mem_wdata=0xDEADBEEF; done 2 cycles after accept; err=0.
- After that store, LB addr=0x13 → rdata=0xFFFFFFDE. LHU addr=0x12 → rdata=0x0000DEAD. LW addr=0x10 → 0xDEADBEEF. Each has mem_read high for exactly one cycle and done 3 cycles after accept.
- SB wdata=0x00000055, addr=0x11 → memory word 4 becomes 0xDEAD55EF; a subsequent LW returns it; done 4 cycles after accept.
- LH addr=0x11 → err=1 and done 1 cycle after accept; mem_read/mem_write never asserted; rdata unchanged.
- Reset asserted during CAP of an SH → busy=0 and mem_write=0 immediately; the memory word is unchanged; the next SW completes normally.
- LW addr=0x00000090:
  - With LSU_RANGE_CHECK_EN: err=1, no access.
  - Without it: reads word index 4.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Core-side initiator for a single-cycle, word-wide data memory.
// It handles loads LB/LH/LW/LBU/LHU, with sign or zero extension of the result,
// and stores SB/SH/SW. The memory only writes whole words, so SB and SH are
// done as read-modify-write.
//
// Optional feature: define LSU_RANGE_CHECK_EN to reject any address whose bits
// above the memory range are non-zero. When it is undefined, those upper bits
// are ignored and addresses alias onto the memory.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   req            request strobe, sampled only while idle
//   we             1 = store, 0 = load
//   funct3         RISC-V size/sign code
//   addr           byte address
//   wdata          store data
//   busy           high while an operation is in progress
//   done           one-cycle completion pulse
//   err            request rejected; held until the next accepted request
//   rdata          load result, updated only by successful loads
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   mem_addr       word index
//   mem_wdata      memory write data
//   mem_rdata      memory read data, valid the cycle after mem_read
module load_store_unit #(
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [IDX_BITS-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic                we_reg;
  logic [2:0]          f3_reg;
  logic [IDX_BITS+1:0] addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         wbuf_reg;
  logic [31:0]         rdata_reg;
  logic                err_reg;

  // Request validity, decoded from the live inputs at accept time.
  logic bad_f3, bad_store, misaligned, out_of_range, invalid_req;

  assign bad_f3     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign bad_store  = we && funct3[2];
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = |addr[31:IDX_BITS+2];
`else
  assign out_of_range = 1'b0;
  // Upper address bits alias in this build; they are intentionally unused.
  logic unused_upper_addr;
  assign unused_upper_addr = &{1'b0, addr[31:IDX_BITS+2]};
`endif

  assign invalid_req = bad_f3 || bad_store || misaligned || out_of_range;

  // SW goes straight to the write; everything else valid reads first.
  logic is_sw;
  assign is_sw = we && (funct3 == 3'b010);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (invalid_req)  state_next = DONE;
          else if (is_sw)   state_next = WR;
          else              state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_reg ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load lane extraction and extension.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;

  always_comb begin
    sel_byte = 8'h00;
    case (addr_reg[1:0])
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (f3_reg[1:0])
      2'b00:   load_val = {{24{sel_byte[7] & ~f3_reg[2]}}, sel_byte};
      2'b01:   load_val = {{16{sel_half[15] & ~f3_reg[2]}}, sel_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word store merge: each byte lane either takes new store data or
  // keeps the byte just read from memory.
  logic [31:0] merged;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi;
      logic       lane_en;
      logic [7:0] new_byte;
      assign lane_en  = (f3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == LANE)
                                               : (addr_reg[1] == LANE[1]);
      assign new_byte = (f3_reg[1:0] == 2'b00) ? wdata_reg[7:0]
                                               : wdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = lane_en ? new_byte : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      f3_reg    <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      wbuf_reg  <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg    <= we;
            f3_reg    <= funct3;
            addr_reg  <= addr[IDX_BITS+1:0];
            wdata_reg <= wdata;
            err_reg   <= invalid_req;
            // SW needs no merge, so its data goes directly to the write buffer.
            if (!invalid_req && is_sw) wbuf_reg <= wdata;
          end
        end
        CAP: begin
          if (we_reg) wbuf_reg  <= merged;
          else        rdata_reg <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign mem_read  = (state_reg == RD);
  assign mem_write = (state_reg == WR);
  assign mem_addr  = addr_reg[IDX_BITS+1:2];
  assign mem_wdata = wbuf_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: drives a table of requests against a simple
// registered-read memory and checks each completion taken from a scoreboard queue.
module tb_load_store_unit;

  localparam int IDX_BITS = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                req;
  logic                we;
  logic [2:0]          funct3;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic                busy;
  logic                done;
  logic                err;
  logic [31:0]         rdata;
  logic                mem_read;
  logic                mem_write;
  logic [IDX_BITS-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: whole-word writes, registered read.
  logic [31:0] tmem [0:(1<<IDX_BITS)-1];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<IDX_BITS); i++) tmem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_write) tmem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= tmem[mem_addr];
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [4:0]  exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:18];
  vec_t sbq [$];

  function automatic vec_t mk(string nm, logic w, logic [2:0] f, logic [31:0] a,
                              logic [31:0] d, logic e, int lat, int nrd, int nwr,
                              logic [4:0] ma, logic [31:0] mw, logic [31:0] rd);
    vec_t v;
    v.name = nm; v.we = w; v.f3 = f; v.addr = a; v.wdata = d;
    v.exp_err = e; v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
    v.exp_maddr = ma; v.exp_mwdata = mw; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, " idle-timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run(vec_t v);
    vec_t e;
    int lat, nrd, nwr;
    logic seen;
    wait_idle(v.name);
    we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; req = 1'b1;
    sbq.push_back(v);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 1; nrd = 0; nwr = 0; seen = 1'b0;
    while (!seen && lat <= 8) begin
      if (mem_read && mem_write) chk({v.name, " rd&wr"}, 32'd1, 32'd0);
      if (mem_read) begin
        nrd++;
        chk({v.name, " rd-addr"}, 32'(mem_addr), 32'(v.exp_maddr));
      end
      if (mem_write) begin
        nwr++;
        chk({v.name, " wr-addr"}, 32'(mem_addr), 32'(v.exp_maddr));
        chk({v.name, " wr-data"}, mem_wdata, v.exp_mwdata);
      end
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) begin
      chk({v.name, " done-timeout"}, 32'd1, 32'd0);
      void'(sbq.pop_front());
      return;
    end
    e = sbq.pop_front();
    chk({e.name, " latency"}, 32'(lat), 32'(e.exp_lat));
    chk({e.name, " err"}, 32'(err), 32'(e.exp_err));
    chk({e.name, " rdata"}, rdata, e.exp_rdata);
    chk({e.name, " reads"}, 32'(nrd), 32'(e.exp_rd));
    chk({e.name, " writes"}, 32'(nwr), 32'(e.exp_wr));
    $display("txn %s addr=%h err=%0b rdata=%h lat=%0d rd=%0d wr=%0d",
             e.name, e.addr, err, rdata, lat, nrd, nwr);
    @(negedge clk);
    chk({e.name, " err-held"}, 32'(err), 32'(e.exp_err));
    chk({e.name, " done-pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nwr, n;
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_read", 32'(mem_read), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = mk("SW@10",   1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 2, 0, 1, 5'd4,  32'hDEADBEEF, 32'h0);
    vecs[1]  = mk("LB@13",   0, 3'b000, 32'h13, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'hFFFFFFDE);
    vecs[2]  = mk("LHU@12",  0, 3'b101, 32'h12, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'h0000DEAD);
    vecs[3]  = mk("LW@10",   0, 3'b010, 32'h10, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'hDEADBEEF);
    vecs[4]  = mk("SB@11",   1, 3'b000, 32'h11, 32'h00000055, 0, 4, 1, 1, 5'd4,  32'hDEAD55EF, 32'hDEADBEEF);
    vecs[5]  = mk("LW@10b",  0, 3'b010, 32'h10, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'hDEAD55EF);
    vecs[6]  = mk("LH@11",   0, 3'b001, 32'h11, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'hDEAD55EF);
    vecs[7]  = mk("LB@11",   0, 3'b000, 32'h11, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'h00000055);
    vecs[8]  = mk("SH@06",   1, 3'b001, 32'h06, 32'h00008000, 0, 4, 1, 1, 5'd1,  32'h80000000, 32'h00000055);
    vecs[9]  = mk("LH@06",   0, 3'b001, 32'h06, 32'h0,        0, 3, 1, 0, 5'd1,  32'h0, 32'hFFFF8000);
    vecs[10] = mk("LHU@06",  0, 3'b101, 32'h06, 32'h0,        0, 3, 1, 0, 5'd1,  32'h0, 32'h00008000);
    vecs[11] = mk("SB@7C",   1, 3'b000, 32'h7C, 32'h123456F0, 0, 4, 1, 1, 5'd31, 32'h000000F0, 32'h00008000);
    vecs[12] = mk("LB@7C",   0, 3'b000, 32'h7C, 32'h0,        0, 3, 1, 0, 5'd31, 32'h0, 32'hFFFFFFF0);
    vecs[13] = mk("LBU@7C",  0, 3'b100, 32'h7C, 32'h0,        0, 3, 1, 0, 5'd31, 32'h0, 32'h000000F0);
    vecs[14] = mk("F3=011",  0, 3'b011, 32'h00, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'h000000F0);
    vecs[15] = mk("SBU",     1, 3'b100, 32'h00, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'h000000F0);
    vecs[16] = mk("SW@12",   1, 3'b010, 32'h12, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'h000000F0);
    vecs[17] = mk("F3=110",  0, 3'b110, 32'h00, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'h000000F0);
`ifdef LSU_RANGE_CHECK_EN
    vecs[18] = mk("LW@90",   0, 3'b010, 32'h90, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0, 32'h000000F0);
`else
    vecs[18] = mk("LW@90",   0, 3'b010, 32'h90, 32'h0,        0, 3, 1, 0, 5'd4,  32'h0, 32'hDEAD55EF);
`endif

    for (int i = 0; i < 19; i++) run(vecs[i]);

    // req held high with store fields while a load is busy: nothing but the
    // load may happen.
    wait_idle("ignore");
    we = 1'b0; funct3 = 3'b010; addr = 32'h7C; wdata = 32'h0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; wdata = 32'hFFFFFFFF;
    nwr = 0; n = 0;
    while (!done && n < 8) begin
      if (mem_write) nwr++;
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    chk("ignore done-seen", 32'(done), 32'd1);
    chk("ignore writes", 32'(nwr), 32'd0);
    chk("ignore rdata", rdata, 32'h000000F0);
    @(negedge clk);
    chk("ignore mem31", tmem[31], 32'h000000F0);
    $display("txn ignore-while-busy rdata=%h writes=%0d", rdata, nwr);

    // Reset during CAP of an SH: write never happens, memory unchanged.
    wait_idle("rstcap");
    we = 1'b1; funct3 = 3'b001; addr = 32'h10; wdata = 32'h00001111; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstcap busy", 32'(busy), 32'd0);
    chk("rstcap mem_write", 32'(mem_write), 32'd0);
    chk("rstcap mem_read", 32'(mem_read), 32'd0);
    chk("rstcap done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rstcap mem_write2", 32'(mem_write), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstcap no-done", 32'(done), 32'd0);
    end
    chk("rstcap mem4", tmem[4], 32'hDEAD55EF);
    chk("rstcap rdata", rdata, 32'h0);
    $display("txn reset-in-cap mem4=%h busy=%0b", tmem[4], busy);

    run(mk("SW@10r", 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 2, 0, 1, 5'd4, 32'hCAFEF00D, 32'h0));
    run(mk("LW@10r", 0, 3'b010, 32'h10, 32'h0,        0, 3, 1, 0, 5'd4, 32'h0, 32'hCAFEF00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
